// File: rtl/virtual_adc_gen.sv
// Behavioural LTC2387-style serial ADC model: oversamples cnv/clk, waits a conversion
// time, then shifts one sample MSB-first onto one or two DDR lanes echoing clk as dco.
module virtual_adc_gen #(
    parameter int ADC_WIDTH = 18,
    parameter int LANES     = 2,
    parameter int DEPTH     = 16,
    parameter int T_CONV    = 4,
    parameter int STEP      = 1
) (
    input  logic                     fast_clk,
    input  logic                     reset,
    input  logic                     cnv_i,
    input  logic                     clk_i,
    input  logic [1:0]               mode_i,
    input  logic [ADC_WIDTH-1:0]     fixed_value_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [ADC_WIDTH-1:0]     wr_data_i,
    output logic                     dco_o,
    output logic                     da_o,
    output logic                     db_o,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic                     overrun_o
);
    localparam int W   = ADC_WIDTH;
    localparam int P   = (W + LANES - 1) / LANES;
    localparam int LW  = LANES * P;
    localparam int E   = 2 * ((P + 1) / 2);
    localparam int AW  = $clog2(DEPTH);
    localparam int ECW = $clog2(E + 1);
    localparam int TCW = $clog2(T_CONV + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, OUTPUT = 2'd2} state_t;

    state_t          state_q;
    logic [2:0]      cnv_sync_q;
    logic [2:0]      clk_sync_q;
    logic            cnv_rise_s;
    logic            clk_edge_s;
    logic [1:0]      mode_q;
    logic [TCW-1:0]  conv_cnt_q;
    logic [ECW-1:0]  edge_cnt_q;
    logic [LW-1:0]   shreg_q;
    logic [AW-1:0]   idx_q;
    logic [W-1:0]    ctr_q;
    logic            chk_q;
    logic            dco_q;
    logic            da_q;
    logic            db_q;
    logic            busy_q;
    logic            frame_done_q;
    logic            overrun_q;
    logic [W-1:0]    table_q [DEPTH];
    logic [W-1:0]    sample_d;
    logic [LW-1:0]   word_d;

    // phase 0 gives 1010... from the MSB, phase 1 gives 0101...
    function automatic logic [W-1:0] checker_word(input logic phase);
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) begin
            w[i] = (((W - 1 - i) % 2) == 0) ? ~phase : phase;
        end
        return w;
    endfunction

    assign cnv_rise_s = cnv_sync_q[1] & ~cnv_sync_q[2];
    assign clk_edge_s = clk_sync_q[1] ^ clk_sync_q[2];

    // Sample selection at conversion end; word is left-aligned with zero LSB padding
    always_comb begin
        sample_d = '0;
        case (mode_q)
            2'd0:    sample_d = table_q[idx_q];
            2'd1:    sample_d = ctr_q;
            2'd2:    sample_d = fixed_value_i;
            2'd3:    sample_d = checker_word(chk_q);
            default: sample_d = '0;
        endcase
        word_d = LW'(sample_d) << (LW - W);
    end

    // Sample table: write port only, contents deliberately survive reset
    always_ff @(posedge fast_clk) begin
        if (wr_en_i) begin
            table_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Synchronisers, conversion/serialisation FSM and registered outputs
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnv_sync_q   <= 3'b000;
            clk_sync_q   <= 3'b000;
            mode_q       <= 2'd0;
            conv_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            shreg_q      <= '0;
            idx_q        <= '0;
            ctr_q        <= '0;
            chk_q        <= 1'b0;
            dco_q        <= 1'b0;
            da_q         <= 1'b0;
            db_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnv_sync_q   <= {cnv_sync_q[1:0], cnv_i};
            clk_sync_q   <= {clk_sync_q[1:0], clk_i};
            frame_done_q <= 1'b0;
            if (cnv_rise_s && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cnv_rise_s) begin
                        state_q    <= CONVERT;
                        busy_q     <= 1'b1;
                        mode_q     <= mode_i;
                        conv_cnt_q <= '0;
                    end
                end
                CONVERT: begin
                    if (conv_cnt_q == TCW'(T_CONV - 1)) begin
                        state_q    <= OUTPUT;
                        busy_q     <= 1'b0;
                        edge_cnt_q <= '0;
                        da_q       <= word_d[LW-1];
                        db_q       <= (LANES == 2) ? word_d[LW-2] : 1'b0;
                        shreg_q    <= word_d << LANES;
                        case (mode_q)
                            2'd0:    idx_q <= idx_q + AW'(1);
                            2'd1:    ctr_q <= ctr_q + W'(STEP);
                            2'd3:    chk_q <= ~chk_q;
                            default: chk_q <= chk_q;
                        endcase
                    end else begin
                        conv_cnt_q <= conv_cnt_q + TCW'(1);
                    end
                end
                OUTPUT: begin
                    if (clk_edge_s) begin
                        if (edge_cnt_q == ECW'(E - 1)) begin
                            state_q      <= IDLE;
                            dco_q        <= 1'b0;
                            da_q         <= 1'b0;
                            db_q         <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            edge_cnt_q <= edge_cnt_q + ECW'(1);
                            dco_q      <= clk_sync_q[1];
                            da_q       <= shreg_q[LW-1];
                            db_q       <= (LANES == 2) ? shreg_q[LW-2] : 1'b0;
                            shreg_q    <= shreg_q << LANES;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dco_o        = dco_q;
    assign da_o         = da_q;
    assign db_o         = db_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_virtual_adc_gen.sv
// Directed bench for virtual_adc_gen: three builds (W18/2 lanes, W18/1 lane, W4/2 lanes)
// driven from shared clk/table pins with per-instance cnv.
module tb_virtual_adc_gen;
    logic        fast_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cnv_cmd = 1'b0;
    logic        clk_pin = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [17:0] fixed_value = 18'h0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [17:0] wr_data = 18'h0;
    int          sel = 0;
    int          checks = 0;
    int          fails = 0;

    logic cnv0, cnv1, cnv4;
    logic dco0, da0, db0, busy0, fd0, ov0;
    logic dco1, da1, db1, busy1, fd1, ov1;
    logic dco4, da4, db4, busy4, fd4, ov4;
    logic dco_m, da_m, db_m, busy_m, fd_m;

    assign cnv0 = cnv_cmd & (sel == 0);
    assign cnv1 = cnv_cmd & (sel == 1);
    assign cnv4 = cnv_cmd & (sel == 2);

    always #5 fast_clk = ~fast_clk;

    virtual_adc_gen #(.ADC_WIDTH(18), .LANES(2), .DEPTH(16), .T_CONV(4), .STEP(1)) dut (
        .fast_clk(fast_clk), .reset(reset), .cnv_i(cnv0), .clk_i(clk_pin), .mode_i(mode),
        .fixed_value_i(fixed_value), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .dco_o(dco0), .da_o(da0), .db_o(db0), .busy_o(busy0), .frame_done_o(fd0), .overrun_o(ov0));

    virtual_adc_gen #(.ADC_WIDTH(18), .LANES(1), .DEPTH(16), .T_CONV(4), .STEP(1)) dut_l1 (
        .fast_clk(fast_clk), .reset(reset), .cnv_i(cnv1), .clk_i(clk_pin), .mode_i(mode),
        .fixed_value_i(fixed_value), .wr_en_i(1'b0), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .dco_o(dco1), .da_o(da1), .db_o(db1), .busy_o(busy1), .frame_done_o(fd1), .overrun_o(ov1));

    virtual_adc_gen #(.ADC_WIDTH(4), .LANES(2), .DEPTH(16), .T_CONV(4), .STEP(1)) dut_w4 (
        .fast_clk(fast_clk), .reset(reset), .cnv_i(cnv4), .clk_i(clk_pin), .mode_i(mode),
        .fixed_value_i(fixed_value[3:0]), .wr_en_i(1'b0), .wr_addr_i(wr_addr), .wr_data_i(wr_data[3:0]),
        .dco_o(dco4), .da_o(da4), .db_o(db4), .busy_o(busy4), .frame_done_o(fd4), .overrun_o(ov4));

    always_comb begin
        case (sel)
            1:       begin dco_m = dco1; da_m = da1; db_m = db1; busy_m = busy1; fd_m = fd1; end
            2:       begin dco_m = dco4; da_m = da4; db_m = db4; busy_m = busy4; fd_m = fd4; end
            default: begin dco_m = dco0; da_m = da0; db_m = db0; busy_m = busy0; fd_m = fd0; end
        endcase
    end

    function automatic logic [17:0] word2(input logic [63:0] pa, input logic [63:0] pb);
        logic [17:0] w;
        for (int k = 0; k < 9; k++) begin
            w[17-2*k] = pa[k];
            w[16-2*k] = pb[k];
        end
        return w;
    endfunction

    function automatic logic [17:0] word1(input logic [63:0] pa);
        logic [17:0] w;
        for (int k = 0; k < 18; k++) w[17-k] = pa[k];
        return w;
    endfunction

    function automatic logic [3:0] word4(input logic [63:0] pa, input logic [63:0] pb);
        return {pa[0], pb[0], pa[1], pb[1]};
    endfunction

    // One conversion plus 'pulses' clk pulses; index e holds lanes/dco sampled after clk edge e
    task automatic run_frame(input int s, input int pulses, input logic [1:0] m, input int ovr,
                             output logic [63:0] pa, output logic [63:0] pb, output logic [63:0] pd,
                             output int lat, output int blen, output int fdc, output logic fd_last);
        sel = s; mode = m; pa = '0; pb = '0; pd = '0; fdc = 0; fd_last = 1'b0;
        @(negedge fast_clk);
        cnv_cmd = 1'b1;
        lat = 0;
        do begin
            @(negedge fast_clk);
            lat++;
        end while (!busy_m && lat < 20);
        cnv_cmd = 1'b0;
        blen = 0;
        while (busy_m && blen < 20) begin
            cnv_cmd = (ovr == 1 && blen == 1);
            @(negedge fast_clk);
            blen++;
        end
        cnv_cmd = 1'b0;
        checks++;
        if (lat >= 20 || blen >= 20) begin
            fails++;
            $display("FAIL frame_timeout: lat=%0d blen=%0d required both < 20", lat, blen);
        end
        pa[0] = da_m; pb[0] = db_m; pd[0] = dco_m;
        if (fd_m) fdc++;
        for (int e = 1; e <= 2 * pulses; e++) begin
            clk_pin = e[0];
            cnv_cmd = (ovr == 2 && e == 2);
            repeat (3) @(negedge fast_clk);
            pa[e] = da_m; pb[e] = db_m; pd[e] = dco_m;
            fd_last = fd_m;
            if (fd_m) fdc++;
            @(negedge fast_clk);
            if (fd_m) fdc++;
        end
        cnv_cmd = 1'b0;
        repeat (2) @(negedge fast_clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge fast_clk);
        checks++;
        if ({dco0, da0, db0, busy0, fd0, ov0, dco1, da1, db1, busy1, dco4, da4, db4, busy4} !== 14'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required all 0",
                     {dco0, da0, db0, busy0, fd0, ov0, dco1, da1, db1, busy1, dco4, da4, db4, busy4});
        end
        reset = 1'b0;
        repeat (3) @(negedge fast_clk);
    endtask

    task automatic test_fixed();
        logic [63:0] pa, pb, pd; int lat, blen, fdc; logic fdl;
        fixed_value = 18'h2AAAA;
        run_frame(0, 5, 2'd2, 0, pa, pb, pd, lat, blen, fdc, fdl);
        checks++; if (lat !== 3) begin fails++; $display("FAIL cnv_to_busy: got %0d required 3", lat); end
        checks++; if (blen !== 4) begin fails++; $display("FAIL busy_len: got %0d required 4", blen); end
        checks++; if (pa[10:0] !== 11'h1FF) begin fails++; $display("FAIL fixed_da: got %h required 1ff", pa[10:0]); end
        checks++; if (pb[10:0] !== 11'h0) begin fails++; $display("FAIL fixed_db: got %h required 0", pb[10:0]); end
        checks++; if (pd[10:0] !== 11'h2AA) begin fails++; $display("FAIL fixed_dco: got %h required 2aa", pd[10:0]); end
        checks++; if (fdc !== 1 || fdl !== 1'b1) begin fails++; $display("FAIL fixed_frame_done: count %0d last %b required 1/1", fdc, fdl); end
    endtask

    task automatic test_counter();
        logic [63:0] pa, pb, pd; int lat, blen, fdc; logic fdl;
        for (int i = 0; i < 3; i++) begin
            run_frame(0, 5, 2'd1, 0, pa, pb, pd, lat, blen, fdc, fdl);
            checks++;
            if (word2(pa, pb) !== 18'(i)) begin
                fails++; $display("FAIL counter_word%0d: got %h required %h", i, word2(pa, pb), 18'(i));
            end
        end
    endtask

    task automatic test_table();
        logic [63:0] pa, pb, pd; int lat, blen, fdc; logic fdl; logic [17:0] exp_w;
        for (int i = 0; i < 16; i++) begin
            @(negedge fast_clk);
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 18'(i * 18'h1111);
        end
        @(negedge fast_clk);
        wr_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            run_frame(0, 5, 2'd0, 0, pa, pb, pd, lat, blen, fdc, fdl);
            exp_w = 18'((i % 16) * 18'h1111);
            checks++;
            if (word2(pa, pb) !== exp_w) begin
                fails++; $display("FAIL table_word%0d: got %h required %h", i, word2(pa, pb), exp_w);
            end
        end
    endtask

    task automatic test_checker_1lane();
        logic [63:0] pa, pb, pd; int lat, blen, fdc; logic fdl;
        run_frame(1, 9, 2'd3, 0, pa, pb, pd, lat, blen, fdc, fdl);
        checks++; if (word1(pa) !== 18'h2AAAA) begin fails++; $display("FAIL checker_f1: got %h required 2aaaa", word1(pa)); end
        checks++; if (pb !== 64'h0) begin fails++; $display("FAIL checker_db: got %h required 0", pb); end
        checks++; if (pa[18] !== 1'b0 || fdc !== 1) begin fails++; $display("FAIL checker_end: da %b fd %0d required 0/1", pa[18], fdc); end
        run_frame(1, 9, 2'd3, 0, pa, pb, pd, lat, blen, fdc, fdl);
        checks++; if (word1(pa) !== 18'h15555) begin fails++; $display("FAIL checker_f2: got %h required 15555", word1(pa)); end
    endtask

    task automatic test_w4_wrap();
        logic [63:0] pa, pb, pd; int lat, blen, fdc; logic fdl;
        for (int i = 0; i < 17; i++) begin
            run_frame(2, 1, 2'd1, 0, pa, pb, pd, lat, blen, fdc, fdl);
            if (i == 1 || i == 15 || i == 16) begin
                checks++;
                if (word4(pa, pb) !== 4'(i % 16)) begin
                    fails++; $display("FAIL w4_counter%0d: got %h required %h", i, word4(pa, pb), 4'(i % 16));
                end
            end
        end
        checks++; if (fdc !== 1) begin fails++; $display("FAIL w4_frame_done: got %0d required 1", fdc); end
    endtask

    task automatic test_overrun();
        logic [63:0] pa, pb, pd; int lat, blen, fdc; logic fdl;
        fixed_value = 18'h1E0F5;
        run_frame(0, 5, 2'd2, 1, pa, pb, pd, lat, blen, fdc, fdl);
        checks++; if (word2(pa, pb) !== 18'h1E0F5 || fdc !== 1) begin fails++; $display("FAIL ovr_conv_word: got %h fd %0d required 1e0f5/1", word2(pa, pb), fdc); end
        checks++; if (ov0 !== 1'b1) begin fails++; $display("FAIL ovr_conv_flag: got %b required 1", ov0); end
        fixed_value = 18'h0C3A6;
        run_frame(0, 5, 2'd2, 2, pa, pb, pd, lat, blen, fdc, fdl);
        checks++; if (word2(pa, pb) !== 18'h0C3A6 || fdc !== 1) begin fails++; $display("FAIL ovr_out_word: got %h fd %0d required 0c3a6/1", word2(pa, pb), fdc); end
        checks++; if (ov0 !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b required 1", ov0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] pa, pb, pd; int lat, blen, fdc; logic fdl; int n;
        sel = 0; mode = 2'd0;
        @(negedge fast_clk);
        cnv_cmd = 1'b1;
        n = 0;
        while (!busy0 && n < 20) begin @(negedge fast_clk); n++; end
        cnv_cmd = 1'b0;
        while (busy0 && n < 40) begin @(negedge fast_clk); n++; end
        checks++; if (n >= 40) begin fails++; $display("FAIL mid_timeout: waited %0d cycles required < 40", n); end
        for (int e = 1; e <= 4; e++) begin
            clk_pin = e[0];
            repeat (4) @(negedge fast_clk);
        end
        // table[1] = 0x01111: pair 4 carries bits 9/8 = 0/1
        checks++; if ({da0, db0} !== 2'b01) begin fails++; $display("FAIL mid_pair4: got %b required 01", {da0, db0}); end
        reset = 1'b1;
        #1;
        checks++;
        if ({dco0, da0, db0, busy0, fd0, ov0} !== 6'h0) begin
            fails++; $display("FAIL mid_reset_outputs: got %b required 000000", {dco0, da0, db0, busy0, fd0, ov0});
        end
        @(negedge fast_clk);
        reset = 1'b0;
        repeat (3) @(negedge fast_clk);
        run_frame(0, 5, 2'd0, 0, pa, pb, pd, lat, blen, fdc, fdl);
        checks++; if (word2(pa, pb) !== 18'h00000 || fdc !== 1) begin fails++; $display("FAIL post_reset_word0: got %h fd %0d required 00000/1", word2(pa, pb), fdc); end
        run_frame(0, 5, 2'd0, 0, pa, pb, pd, lat, blen, fdc, fdl);
        checks++; if (word2(pa, pb) !== 18'h01111) begin fails++; $display("FAIL post_reset_word1: got %h required 01111", word2(pa, pb)); end
        checks++; if (ov0 !== 1'b0) begin fails++; $display("FAIL post_reset_overrun: got %b required 0", ov0); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_counter();
        test_table();
        test_checker_1lane();
        test_w4_wrap();
        test_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/virtual_adc_gen.md
# virtual_adc_gen

Parametrised behavioural model of an LTC2387-style serial ADC for simulation and loopback testing of the capture path. It detects a conversion request on `cnv`, waits a programmable conversion time, then serialises one sample MSB-first onto one or two DDR lanes (`da`/`db`) clocked by the host-supplied `clk` burst, echoing `clk` as `dco`. Samples come from a writable table, a counter, a fixed value or a checkerboard, selected per conversion. Everything is clocked from `fast_clk`; `clk` and `cnv` are oversampled.

## Interface
- `ADC_WIDTH`, 18, sample width W (≥4)
- `LANES`, 2, 1 or 2 output lanes
- `DEPTH`, 16, sample-table entries (≥2, power of 2)
- `T_CONV`, 4, conversion time in `fast_clk` cycles (≥1)
- `STEP`, 1, counter-mode increment
---
- `fast_clk` in 1: model clock
- `reset` in 1: asynchronous, active-high
- `cnv` in 1: conversion start, rising edge
- `clk` in 1: host ADC clock burst, each phase ≥3 `fast_clk` cycles
- `mode` in 2: 0 table, 1 counter, 2 fixed, 3 checkerboard; sampled at `cnv` rise
- `fixed_value` in W: mode-2 data, sampled at end of conversion
- `wr_en` in 1: table write strobe
- `wr_addr` in $clog2(DEPTH): table write address
- `wr_data` in W: table write data
- `dco` out 1: echoed `clk`, 0 outside a frame
- `da` out 1: lane A data
- `db` out 1: lane B data, 0 when LANES=1
- `busy` out 1: high during conversion
- `frame_done` out 1: one-cycle pulse at frame end
- `overrun` out 1: sticky, `cnv` rise while not IDLE

## Operation
- Reset: state IDLE; `dco`,`da`,`db`,`busy`,`frame_done`,`overrun` = 0; table index = 0; counter = 0; sync flops = 0. Table contents not reset.
- `cnv` and `clk` each pass a 2-flop synchroniser; edges detected by comparing the 2nd flop with a 3rd.
- States: IDLE → CONVERT (on `cnv` rise; latch `mode`; `busy`=1) → OUTPUT (after T_CONV cycles; `busy`=0) → IDLE (frame end).
- Sample source at conversion end: table[idx], then idx+1 mod DEPTH; counter value, then counter+STEP mod 2^W; `fixed_value`; checkerboard alternates 1010…/0101… (first frame after reset 1010…, toggles per frame in mode 3 only).
- Bits per lane P = ceil(W/LANES). Word is left-aligned into LANES·P bits, LSB padding 0.
- LANES=2: pair k drives `da` = bit W-1-2k, `db` = bit W-2-2k. LANES=1: `da` = bit W-1-k.
- Pair 0 presented on the cycle entering OUTPUT. Each detected `clk` edge (either polarity) advances k; pairs k ≥ P drive 0.
- Frame ends on edge number E = 2·ceil(P/2) (W=18, LANES=2: P=9, E=10, five `clk` pulses): `da`/`db`/`dco` → 0, `frame_done` pulses, state IDLE.
- `cnv` rise in CONVERT or OUTPUT: ignored, `overrun` set. `cnv` rise on the cycle of return to IDLE is ignored; next conversion needs a rise detected in IDLE.
- `clk` edges in IDLE or CONVERT: ignored, `dco` stays 0.
- Table write in same cycle as table read at conversion end: read returns old data.
- Reset mid-frame: immediate IDLE, all outputs 0, partial frame discarded.

## Timing
- `cnv` pin rise → `busy` high: 3 `fast_clk` cycles (2 sync + detect).
- `busy` high exactly T_CONV cycles; pair 0 appears the cycle `busy` falls.
- `clk` pin edge → `dco` edge and new pair: 3 cycles; `dco`, `da`, `db` change on the same `fast_clk` edge.
- `frame_done` asserts the cycle `dco` returns to 0 on edge E.
- Counter/index update on the conversion-end cycle.

## Test plan
- W=18, LANES=2, mode 2, `fixed_value`=0x2AAAA, 5 `clk` pulses → `da` 1×9 then 0, `db` 0×10, `frame_done` once after 10th edge.
- Mode 1, STEP=1, three conversions → deserialised words 0x00000, 0x00001, 0x00002; after 2^18 frames wraps to 0 (shortened with W=4 build: 0xF → 0x0).
- Mode 0, write table[0..15]=i·0x1111, 17 conversions → words 0x0000…0xFFFF then 0x0000 (index wrap).
- LANES=1, W=18, mode 3 → frame 1 `da` = 101010…(18 bits), frame 2 = 010101…; 9 `clk` pulses per frame; `db` always 0.
- `cnv` rise during CONVERT and during OUTPUT → frame unaffected, `overrun`=1 and stays 1 until reset.
- `reset` after 4th `clk` edge → outputs 0 same cycle; next `cnv` produces a full clean frame; table contents intact.
